serial_add_sub_comp: RTL and testbench

Bit-serial responder for the add/subtract/compare operation protocol used by the N-bit `add_sub_comp` datapath. It accepts one request per handshake: operands `a`/`b`, carry-in, borrow-in and a one-hot operation select (`oprtn1`=add, `oprtn2`=sub, `oprtn3`=compare). It processes one bit per clock, LSB first, and returns results through a valid/ready response port. It sits behind an operation initiator (a sequencer or bench) and replaces the combinational unit where area matters more than latency.

---
 rtl/serial_add_sub_comp.sv | 148 ++++++++++++++
 tb/tb_serial_add_sub_comp.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub_comp.sv
// serial_add_sub_comp: bit-serial add/sub/compare responder, LSB first, one bit per clock.
// Optional SERIAL_ARITH_OVF_EN adds the signed-overflow output ovf.
module serial_add_sub_comp #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         borin,
   input  logic         oprtn1,
   input  logic         oprtn2,
   input  logic         oprtn3,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic [N-1:0] diff,
   output logic         borout,
   output logic         aisbig,
   output logic         bisbig,
   output logic         equal,
`ifdef SERIAL_ARITH_OVF_EN
   output logic         ovf,
`endif
   output logic         err
);
   localparam int CW = (N > 2) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [N-1:0]    a_q, b_q, res_q, sum_q, diff_q;
   logic [2:0]      op_q;
   logic            c_q, gt_q, lt_q, req_ready_q, rsp_valid_q;
   logic            cout_q, borout_q, aisbig_q, bisbig_q, equal_q, err_q, ovf_q;
   logic            ai, bi, s_d, c_d, gt_d, lt_d, last_d, onehot_d;
   logic [2:0]      sel_d;
   logic [N-1:0]    res_d;
   // per-bit serial datapath; op_q is {add, sub, cmp}, all-zero marks an illegal request
   always_comb begin
      ai       = a_q[0];
      bi       = b_q[0];
      sel_d    = {oprtn1, oprtn2, oprtn3};
      onehot_d = (sel_d == 3'b100) | (sel_d == 3'b010) | (sel_d == 3'b001);
      s_d      = ai ^ bi ^ c_q;
      c_d      = op_q[1] ? ((~ai & bi) | (~(ai ^ bi) & c_q)) : ((ai & bi) | (ai & c_q) | (bi & c_q));
      gt_d     = (ai ^ bi) ? ai : gt_q;
      lt_d     = (ai ^ bi) ? bi : lt_q;
      res_d    = {s_d, res_q[N-1:1]};
      last_d   = (cnt_q == CW'(N - 1)) | ~|op_q;
   end
   // control FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         op_q        <= '0;
         c_q         <= 1'b0;
         gt_q        <= 1'b0;
         lt_q        <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         sum_q       <= '0;
         diff_q      <= '0;
         cout_q      <= 1'b0;
         borout_q    <= 1'b0;
         aisbig_q    <= 1'b0;
         bisbig_q    <= 1'b0;
         equal_q     <= 1'b0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               a_q         <= a;
               b_q         <= b;
               op_q        <= onehot_d ? sel_d : 3'b000;
               cnt_q       <= '0;
               res_q       <= '0;
               c_q         <= oprtn1 ? cin : (oprtn2 & borin);
               gt_q        <= 1'b0;
               lt_q        <= 1'b0;
               req_ready_q <= 1'b0;
               state_q     <= RUN;
            end
            RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               res_q <= res_d;
               c_q   <= c_d;
               gt_q  <= gt_d;
               lt_q  <= lt_d;
               cnt_q <= cnt_q + CW'(1);
               if (last_d) begin
                  state_q     <= DONE;
                  rsp_valid_q <= 1'b1;
                  sum_q       <= op_q[2] ? res_d : '0;
                  diff_q      <= op_q[1] ? res_d : '0;
                  cout_q      <= op_q[2] & c_d;
                  borout_q    <= op_q[1] & c_d;
                  aisbig_q    <= op_q[0] & gt_d;
                  bisbig_q    <= op_q[0] & lt_d;
                  equal_q     <= op_q[0] & ~gt_d & ~lt_d;
                  err_q       <= ~|op_q;
                  ovf_q       <= (op_q[2] | op_q[1]) & (c_q ^ c_d);
               end
            end
            DONE: if (rsp_ready) begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               sum_q       <= '0;
               diff_q      <= '0;
               cout_q      <= 1'b0;
               borout_q    <= 1'b0;
               aisbig_q    <= 1'b0;
               bisbig_q    <= 1'b0;
               equal_q     <= 1'b0;
               err_q       <= 1'b0;
               ovf_q       <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign sum       = sum_q;
   assign diff      = diff_q;
   assign cout      = cout_q;
   assign borout    = borout_q;
   assign aisbig    = aisbig_q;
   assign bisbig    = bisbig_q;
   assign equal     = equal_q;
   assign err       = err_q;
`ifdef SERIAL_ARITH_OVF_EN
   assign ovf       = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_sub_comp.sv
// tb_serial_add_sub_comp: scoreboard bench for the serial add/sub/compare responder.
module tb_serial_add_sub_comp;
   localparam int N = 4;
   localparam int W = 2 * N + 7;
   logic clk = 1'b0;
   logic rst, req_valid, req_ready, cin, borin, oprtn1, oprtn2, oprtn3;
   logic rsp_valid, rsp_ready, cout, borout, aisbig, bisbig, equal, err, ovf_w;
   logic [N-1:0] a, b, sum, diff;
   int n_checks = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];
   always #5 clk = ~clk;
   serial_add_sub_comp #(.N(N)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .a(a), .b(b), .cin(cin), .borin(borin),
      .oprtn1(oprtn1), .oprtn2(oprtn2), .oprtn3(oprtn3),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .sum(sum), .cout(cout), .diff(diff), .borout(borout),
      .aisbig(aisbig), .bisbig(bisbig), .equal(equal),
`ifdef SERIAL_ARITH_OVF_EN
      .ovf(ovf_w),
`endif
      .err(err)
   );
`ifndef SERIAL_ARITH_OVF_EN
   assign ovf_w = 1'b0;
`endif
   // expected {sum,cout,diff,borout,aisbig,bisbig,equal,err,ovf}
   function automatic logic [W-1:0] model(input logic [N-1:0] x, y, input logic ci, bw, input logic [2:0] sel);
      logic [N:0] t;
      logic [N-1:0] s, d;
      logic co, bo, ag, bg, eq, er, ov;
      int sx, sy, r, lim;
      s = '0; d = '0; co = 0; bo = 0; ag = 0; bg = 0; eq = 0; er = 0; ov = 0;
      sx = $signed(x); sy = $signed(y); lim = 2 ** (N - 1);
      if (!(sel == 3'b100 || sel == 3'b010 || sel == 3'b001)) er = 1;
      else if (sel[2]) begin
         t = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
         s = t[N-1:0]; co = t[N];
         r = sx + sy + int'(ci);
         ov = (r >= lim) || (r < -lim);
      end else if (sel[1]) begin
         d = x - y - {{(N-1){1'b0}}, bw};
         bo = int'(x) < int'(y) + int'(bw);
         r = sx - sy - int'(bw);
         ov = (r >= lim) || (r < -lim);
      end else begin
         ag = x > y; bg = x < y; eq = x == y;
      end
`ifndef SERIAL_ARITH_OVF_EN
      ov = 0;
`endif
      return {s, co, d, bo, ag, bg, eq, er, ov};
   endfunction
   function automatic logic [W-1:0] observed();
      return {sum, cout, diff, borout, aisbig, bisbig, equal, err, ovf_w};
   endfunction
   task automatic send(input logic [N-1:0] x, y, input logic ci, bw, input logic [2:0] sel,
                       input logic rr, input logic spam, output logic [W-1:0] obs, output int lat);
      int w = 0;
      @(negedge clk);
      while (!req_ready && w < 20) begin @(negedge clk); w++; end
      if (!req_ready) begin
         n_checks++; n_fail++;
         $display("FAIL req_ready_wait: req_ready=%0b required 1", req_ready);
      end
      a = x; b = y; cin = ci; borin = bw; {oprtn1, oprtn2, oprtn3} = sel;
      req_valid = 1; rsp_ready = rr;
      exp_q.push_back(model(x, y, ci, bw, sel));
      @(posedge clk); #1;
      req_valid = spam;
      a = N'($urandom); b = N'($urandom); cin = 1'($urandom); borin = 1'($urandom);
      {oprtn1, oprtn2, oprtn3} = 3'($urandom);
      lat = 0;
      while (!rsp_valid && lat < 3 * N + 10) begin @(posedge clk); #1; lat++; end
      req_valid = 0;
      obs = observed();
   endtask
   task automatic test_reset();
      rst = 1; req_valid = 0; rsp_ready = 0; a = '0; b = '0; cin = 0; borin = 0;
      {oprtn1, oprtn2, oprtn3} = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         n_fail++; $display("FAIL reset_hs: got %b required 10", {req_ready, rsp_valid});
      end
      n_checks++;
      if (observed() !== '0) begin
         n_fail++; $display("FAIL reset_out: got %h required 0", observed());
      end
      @(negedge clk) rst = 0;
   endtask
   task automatic one(input string nm, input logic [N-1:0] x, y, input logic ci, bw, input logic [2:0] sel, input int want_lat);
      logic [W-1:0] obs, e;
      int lat;
      send(x, y, ci, bw, sel, 1'b1, 1'b0, obs, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL %s: got %h required %h", nm, obs, e); end
      n_checks++;
      if (lat !== want_lat) begin n_fail++; $display("FAIL %s_lat: got %0d required %0d", nm, lat, want_lat); end
   endtask
   task automatic test_sub();
      one("sub", 4'b1011, 4'b1101, 1'b0, 1'b1, 3'b010, N);
   endtask
   task automatic test_add();
      one("add", 4'b0100, 4'b1100, 1'b0, 1'b0, 3'b100, N);
      one("add_ovf", 4'b0111, 4'b0001, 1'b0, 1'b0, 3'b100, N);
   endtask
   task automatic test_compare();
      one("cmp_lt", 4'b1011, 4'b1101, 1'b0, 1'b0, 3'b001, N);
      one("cmp_eq", 4'b0110, 4'b0110, 1'b0, 1'b0, 3'b001, N);
      one("cmp_gt", 4'b1000, 4'b0111, 1'b0, 1'b0, 3'b001, N);
   endtask
   task automatic test_illegal();
      one("illegal", 4'b1111, 4'b0000, 1'b1, 1'b1, 3'b011, 1);
   endtask
   task automatic test_backpressure();
      logic [W-1:0] obs, e;
      int lat;
      bit bad = 0;
      send(4'b1110, 4'b1111, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, obs, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL bp_result: got %h required %h", obs, e); end
      repeat (5) begin
         @(posedge clk); #1;
         if (!rsp_valid || req_ready || observed() !== e) bad = 1;
      end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL bp_hold: got %h valid=%0b required %h valid=1", observed(), rsp_valid, e); end
      @(negedge clk) rsp_ready = 1;
      @(posedge clk); #1;
      n_checks++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         n_fail++; $display("FAIL bp_release: got %b required 10", {req_ready, rsp_valid});
      end
   endtask
   task automatic test_reset_abort();
      bit bad = 0;
      @(negedge clk);
      a = 4'b0111; b = 4'b0101; cin = 1; borin = 0; {oprtn1, oprtn2, oprtn3} = 3'b100;
      req_valid = 1; rsp_ready = 1;
      @(posedge clk); #1 req_valid = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      #1;
      n_checks++;
      if ({req_ready, rsp_valid, observed()} !== {2'b10, {W{1'b0}}}) begin
         n_fail++; $display("FAIL abort_reset: got %b %h required 10 0", {req_ready, rsp_valid}, observed());
      end
      @(negedge clk) rst = 0;
      repeat (N + 2) begin @(posedge clk); #1; if (rsp_valid) bad = 1; end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL abort_norsp: got rsp_valid=1 required 0"); end
      one("after_abort", 4'b0001, 4'b0001, 1'b0, 1'b0, 3'b100, N);
   endtask
   task automatic test_back_to_back();
      logic [W-1:0] obs, e;
      logic [2:0] sel;
      int lat, want;
      for (int i = 0; i < 24; i++) begin
         sel = (i % 6 == 5) ? 3'($urandom) : (3'b001 << (i % 3));
         want = (sel == 3'b100 || sel == 3'b010 || sel == 3'b001) ? N : 1;
         send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), sel, 1'b1, 1'b1, obs, lat);
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e || lat !== want) begin
            n_fail++; $display("FAIL b2b_%0d: got %h lat %0d required %h lat %0d", i, obs, lat, e, want);
         end
      end
   endtask
   initial begin
      test_reset();
      test_sub();
      test_add();
      test_compare();
      test_backpressure();
      test_illegal();
      test_reset_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
